// File: rtl/dlfloat16_pkg.sv
// ---------------------------------------------------------------------------
// dlfloat16_pkg
// Shared definitions for the DLFloat16 FPU units.
//   Field widths and bias of the DLFloat16 format (sign[15], exp[14:9],
//   mant[8:0]), special encodings, exception-flag bit positions, FPU opcodes
//   and the FSM state type of the multi-cycle squarer.
// No ports (package).
// ---------------------------------------------------------------------------
package dlfloat16_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 9;
  localparam int BIAS   = 31;

  // DLFloat16 has no infinities: all-ones exponent and mantissa is NaN, and
  // the largest finite value is one ULP below it.
  localparam logic [15:0] DL_NAN    = 16'hFFFF;
  localparam logic [15:0] DL_MAXPOS = 16'h7FFE;
  localparam logic [15:0] DL_ZERO   = 16'h0000;

  // Bit positions inside the 5-bit exception vector
  // {invalid, inexact, overflow, underflow, div_zero}.
  localparam int FLG_INV = 4;
  localparam int FLG_INX = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_DZ  = 0;

  localparam logic [3:0] OP_SQRT   = 4'b0100;
  localparam logic [3:0] OP_SQUARE = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RND  = 2'd2
  } sq_state_t;

endpackage

// File: rtl/dlfloat16_square_if.sv
// ---------------------------------------------------------------------------
// dlfloat16_square_if
// Opcode / handshake / result bundle between the FPU top and the squarer.
//   ena             opcode from the FPU top
//   start           request pulse
//   dl_in           DLFloat16 operand
//   busy            operation in flight
//   done            one-cycle result-valid pulse
//   dl_out_fin      {16'b0, result}
//   exception_flags {invalid, inexact, overflow, underflow, div_zero}
// master: FPU top side. slave: squarer side.
// ---------------------------------------------------------------------------
interface dlfloat16_square_if;

  logic [3:0]  ena;
  logic        start;
  logic [15:0] dl_in;
  logic        busy;
  logic        done;
  logic [31:0] dl_out_fin;
  logic [4:0]  exception_flags;

  modport master (
    output ena, start, dl_in,
    input  busy, done, dl_out_fin, exception_flags
  );

  modport slave (
    input  ena, start, dl_in,
    output busy, done, dl_out_fin, exception_flags
  );

endinterface

// File: rtl/dlfloat16_round_pack.sv
// ---------------------------------------------------------------------------
// dlfloat16_round_pack
// Combinational normalise / round / pack stage for DLFloat16 results.
//   product   in  20  unsigned significand product, leading 1 at bit 19 or 18
//   exp_in    in   8  signed biased exponent assuming the leading 1 at bit 18
//   result    out 16  packed positive DLFloat16 result
//   overflow  out  1  result saturated to the largest finite value
//   underflow out  1  result flushed to zero
//   inexact   out  1  some discarded bit was nonzero (or saturate/flush)
// Rounding is round-to-nearest, ties-to-even, using guard plus sticky.
// ---------------------------------------------------------------------------
module dlfloat16_round_pack
  import dlfloat16_pkg::*;
(
  input  logic [19:0]       product,
  input  logic signed [7:0] exp_in,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  logic [8:0]        mant_t;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [9:0]        mant_sum;
  logic [8:0]        mant_f;
  logic signed [7:0] exp_n;
  logic signed [7:0] exp_f;

  always_comb begin
    mant_t = product[17:9];
    guard  = product[8];
    sticky = |product[7:0];
    exp_n  = exp_in;
    // A product in [2,4) carries its leading 1 one place higher.
    if (product[19]) begin
      mant_t = product[18:10];
      guard  = product[9];
      sticky = |product[8:0];
      exp_n  = exp_in + 8'sd1;
    end

    round_up = guard & (sticky | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {9'b0, round_up};
    // A carry out of the mantissa leaves the low 9 bits at zero already,
    // so only the exponent needs bumping.
    mant_f   = mant_sum[8:0];
    exp_f    = mant_sum[9] ? exp_n + 8'sd1 : exp_n;

    result    = {1'b0, exp_f[5:0], mant_f};
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = guard | sticky;

    // Exponent 63 with an all-ones mantissa is the NaN pattern, so it
    // saturates like any larger exponent.
    if (exp_f > 8'sd63 || (exp_f == 8'sd63 && mant_f == 9'h1FF)) begin
      result   = DL_MAXPOS;
      overflow = 1'b1;
      inexact  = 1'b1;
    end else if (exp_f <= 8'sd0) begin
      result    = DL_ZERO;
      underflow = 1'b1;
      inexact   = 1'b1;
    end
  end

endmodule

// File: rtl/dlfloat16_square.sv
// ---------------------------------------------------------------------------
// dlfloat16_square
// Multi-cycle DLFloat16 squarer (dl_in * dl_in) for the FPU.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of dlfloat16_square_if:
//            ena/start/dl_in in, busy/done/dl_out_fin/exception_flags out
// Accepts start in IDLE when ena==OPCODE, forms the 10x10 significand
// product over 10 shift-add steps, then rounds and packs in one more cycle.
// done pulses 11 clocks after start is sampled, for every operand.
// ---------------------------------------------------------------------------
module dlfloat16_square #(
  parameter logic [3:0] OPCODE = dlfloat16_pkg::OP_SQUARE,
  parameter int         BIAS   = dlfloat16_pkg::BIAS
) (
  input  logic               clk,
  input  logic               rst_n,
  dlfloat16_square_if.slave  bus
);

  dlfloat16_pkg::sq_state_t state;
  dlfloat16_pkg::sq_state_t next_state;

  logic              load;
  logic              step;
  logic              finish;

  // The sign of a square is always positive, so only the magnitude is kept.
  logic [14:0]       op_mag;
  logic [9:0]        sig;
  logic [19:0]       acc;
  logic [3:0]        cnt;
  logic [19:0]       partial;

  logic              done_q;
  logic [15:0]       result_q;
  logic [4:0]        flags_q;

  logic signed [7:0] exp_sq;
  logic [15:0]       rp_result;
  logic              rp_overflow;
  logic              rp_underflow;
  logic              rp_inexact;
  logic              is_nan;
  logic              is_zero;
  logic [15:0]       res_next;
  logic [4:0]        flg_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= dlfloat16_pkg::ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the per-state datapath strobes.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      dlfloat16_pkg::ST_IDLE: begin
        if (bus.start && bus.ena == OPCODE) begin
          load       = 1'b1;
          next_state = dlfloat16_pkg::ST_MUL;
        end
      end
      dlfloat16_pkg::ST_MUL: begin
        step = 1'b1;
        if (cnt == 4'd9) next_state = dlfloat16_pkg::ST_RND;
      end
      dlfloat16_pkg::ST_RND: begin
        finish     = 1'b1;
        next_state = dlfloat16_pkg::ST_IDLE;
      end
      default: next_state = dlfloat16_pkg::ST_IDLE;
    endcase
  end

  assign partial = {10'b0, sig} << cnt;

  // 2*exp - BIAS, the biased exponent of the square before normalisation.
  assign exp_sq  = signed'({1'b0, op_mag[14:9], 1'b0}) - 8'(BIAS);
  assign is_nan  = (op_mag == 15'h7FFF);
  assign is_zero = (op_mag[14:9] == 6'd0);

  dlfloat16_round_pack u_round_pack (
    .product   (acc),
    .exp_in    (exp_sq),
    .result    (rp_result),
    .overflow  (rp_overflow),
    .underflow (rp_underflow),
    .inexact   (rp_inexact)
  );

  // Special operands override the arithmetic path; zero and denormal
  // inputs are flushed to an exact zero.
  always_comb begin
    res_next = rp_result;
    flg_next = '0;
    if (is_nan) begin
      res_next                         = dlfloat16_pkg::DL_NAN;
      flg_next[dlfloat16_pkg::FLG_INV] = 1'b1;
    end else if (is_zero) begin
      res_next = dlfloat16_pkg::DL_ZERO;
    end else begin
      flg_next[dlfloat16_pkg::FLG_INX] = rp_inexact;
      flg_next[dlfloat16_pkg::FLG_OVF] = rp_overflow;
      flg_next[dlfloat16_pkg::FLG_UNF] = rp_underflow;
    end
  end

  // Operand latch, shift-add multiplier and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_mag   <= '0;
      sig      <= '0;
      acc      <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        op_mag <= bus.dl_in[14:0];
        sig    <= {1'b1, bus.dl_in[8:0]};
        acc    <= '0;
        cnt    <= '0;
      end
      if (step) begin
        if (sig[cnt]) acc <= acc + partial;
        cnt <= cnt + 4'd1;
      end
      if (finish) begin
        result_q <= res_next;
        flags_q  <= flg_next;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.busy            = (state != dlfloat16_pkg::ST_IDLE);
  assign bus.done            = done_q;
  assign bus.dl_out_fin      = {16'b0, result_q};
  assign bus.exception_flags = flags_q;

endmodule

// File: tb/tb_dlfloat16_square.sv
// ---------------------------------------------------------------------------
// tb_dlfloat16_square
// Directed bench for dlfloat16_square. Each accepted operation pushes its
// hand-computed result and flags into a scoreboard queue; a monitor pops
// and compares on every done pulse. The stimulus process also checks
// latency, busy, ignored starts and reset abort.
// ---------------------------------------------------------------------------
module tb_dlfloat16_square;
  import dlfloat16_pkg::*;

  typedef struct {
    logic [15:0] op;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic clk;
  logic rst_n;

  dlfloat16_square_if bus ();

  dlfloat16_square #(
    .OPCODE (OP_SQUARE),
    .BIAS   (31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   total_checks = 0;
  int   pass_checks  = 0;
  int   done_count   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) pass_checks++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput($sformatf("result_%04h", e.op), bus.dl_out_fin, e.res);
        checkOutput($sformatf("flags_%04h", e.op), {27'b0, bus.exception_flags},
                    {27'b0, e.flg});
      end
    end
  end

  // Issue one squaring request and follow it to its done pulse. A nonzero
  // glitch_cycle re-pulses start with a different operand while busy.
  task automatic applyStimulus(input logic [15:0] op, input logic [15:0] res,
                               input logic [4:0] flg, input int glitch_cycle);
    exp_t e;
    int   lat;
    int   busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.ena   = OP_SQUARE;
    bus.dl_in = op;
    e.op  = op;
    e.res = {16'b0, res};
    e.flg = flg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the inputs to prove the operand was latched.
    bus.start = 1'b0;
    bus.ena   = 4'b0000;
    bus.dl_in = 16'hFFFF;
    checkOutput($sformatf("busy_start_%04h", op), {31'b0, bus.busy}, 32'd1);
    lat      = 0;
    busy_cnt = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == glitch_cycle) begin
        bus.start = 1'b1;
        bus.ena   = OP_SQUARE;
        bus.dl_in = 16'h6000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_cnt++;
    end
    checkOutput($sformatf("latency_%04h", op), lat, 32'd11);
    checkOutput($sformatf("busy_cycles_%04h", op), busy_cnt, 32'd10);
    checkOutput($sformatf("busy_at_done_%04h", op), {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int dc;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.ena   = 4'b0000;
    bus.dl_in = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
    checkOutput("reset_out", bus.dl_out_fin, 32'd0);
    checkOutput("reset_flags", {27'b0, bus.exception_flags}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Consecutive calls launch the next start during the done cycle.
    applyStimulus(16'h4000, 16'h4200, 5'b00000, 0);
    applyStimulus(16'hC100, 16'h4440, 5'b00000, 5);
    applyStimulus(16'h3F00, 16'h4040, 5'b00000, 0);
    applyStimulus(16'h3E01, 16'h3E02, 5'b01000, 0);
    applyStimulus(16'h3E11, 16'h3E23, 5'b01000, 0);
    applyStimulus(16'h3ED4, 16'h4000, 5'b01000, 0);
    applyStimulus(16'h3FFF, 16'h41FE, 5'b01000, 0);
    applyStimulus(16'h6000, 16'h7FFE, 5'b01100, 0);
    applyStimulus(16'h1E00, 16'h0000, 5'b01010, 0);
    applyStimulus(16'h2000, 16'h0200, 5'b00000, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 5'b10000, 0);
    applyStimulus(16'h8000, 16'h0000, 5'b00000, 0);
    applyStimulus(16'h0005, 16'h0000, 5'b00000, 0);
    applyStimulus(16'h4000, 16'h4200, 5'b00000, 0);

    // A start under the square-root opcode must not be taken.
    repeat (3) @(negedge clk);
    dc = done_count;
    bus.start = 1'b1;
    bus.ena   = OP_SQRT;
    bus.dl_in = 16'h4000;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("wrong_opcode_busy", {31'b0, bus.busy}, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("wrong_opcode_no_done", done_count, dc);

    // Reset in the middle of an operation aborts it silently.
    dc = done_count;
    bus.start = 1'b1;
    bus.ena   = OP_SQUARE;
    bus.dl_in = 16'hC100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
    checkOutput("abort_out", bus.dl_out_fin, 32'd0);
    checkOutput("abort_flags", {27'b0, bus.exception_flags}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", done_count, dc);
    checkOutput("abort_idle", {31'b0, bus.busy}, 32'd0);

    // One more normal operation after the abort.
    applyStimulus(16'hC100, 16'h4440, 5'b00000, 0);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
